// File: rtl/axi_stream_remove_header.sv
// axi_stream_remove_header: strips 0..W header bytes from each packet,
// realigns the payload to word boundaries and reports the stripped bytes.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   valid_in ..       input stream (data_in, keep_in, last_in, ready_in)
//   valid_out ..      realigned stream (data_out, keep_out, last_out,
//                     ready_out)
//   valid_remove ..   strip-count descriptor (byte_remove_cnt,
//                     ready_remove)
//   header_out ..     stripped bytes (header_keep, header_valid pulse)
// Byte 0 of a beat sits in the top lane; keep is left-aligned.

module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD:0]    byte_remove_cnt,
  output logic                    ready_remove,
  output logic [DATA_WD-1:0]      header_out,
  output logic [DATA_BYTE_WD-1:0] header_keep,
  output logic                    header_valid
);

  localparam int CW = BYTE_CNT_WD + 1;
  localparam int SW = BYTE_CNT_WD + 2;
  localparam logic [CW-1:0] W_CNT = CW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {
    IDLE, FIRST, BODY, FLUSH
  } state_t;

  function automatic logic [DATA_BYTE_WD-1:0] lead_ones(
    input logic [SW-1:0] cnt
  );
    logic [DATA_BYTE_WD-1:0] k;
    k = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      k[DATA_BYTE_WD-1-i] = (SW'(i) < cnt);
    return k;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(
    input logic [DATA_BYTE_WD-1:0] k
  );
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [CW-1:0] ones(
    input logic [DATA_BYTE_WD-1:0] k
  );
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      c = c + CW'(k[i]);
    return c;
  endfunction

  state_t              state;
  logic [CW-1:0]       n_q;
  logic [CW-1:0]       fl_q;
  logic [DATA_WD-1:0]  res_q;

  logic                accept;
  logic [CW-1:0]       l_in;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       n_hdr;
  logic [CW-1:0]       fl_nxt;
  logic [SW-1:0]       sum;
  logic [DATA_WD-1:0]  din;
  logic [DATA_WD-1:0]  din_sh;
  logic [DATA_WD-1:0]  body;

  logic                    ld;
  logic                    ld_last;
  logic [DATA_WD-1:0]      ld_data;
  logic [DATA_BYTE_WD-1:0] ld_keep;

  assign ready_remove = (state == IDLE) && !rst;
  assign ready_in = ((state == FIRST) || (state == BODY))
                 && (!valid_out || ready_out);
  assign accept = valid_in && ready_in;

  assign l_in   = ones(keep_in);
  assign r_cnt  = W_CNT - n_q;
  assign n_hdr  = (l_in < n_q) ? l_in : n_q;
  assign fl_nxt = l_in - n_q;
  assign sum    = SW'(r_cnt) + SW'(l_in);

  // Dead lanes are zeroed up front so every shifted word is clean.
  assign din    = data_in & byte_mask(keep_in);
  assign din_sh = din << {n_q, 3'b000};
  assign body   = res_q | (din >> {r_cnt, 3'b000});

  always_comb begin
    ld      = 1'b0;
    ld_last = 1'b0;
    ld_data = '0;
    ld_keep = '0;
    unique case (state)
      FIRST: begin
        if (accept && last_in && (l_in > n_q)) begin
          ld      = 1'b1;
          ld_data = din_sh;
          ld_keep = lead_ones(SW'(fl_nxt));
          ld_last = 1'b1;
        end
      end
      BODY: begin
        if (accept) begin
          if (!last_in) begin
            ld      = 1'b1;
            ld_data = body;
            ld_keep = '1;
          end else if (sum <= SW'(W_CNT)) begin
            ld      = (sum != '0);
            ld_data = body;
            ld_keep = lead_ones(sum);
            ld_last = 1'b1;
          end else begin
            // Tail spills past one word: finish in FLUSH.
            ld      = 1'b1;
            ld_data = body;
            ld_keep = '1;
          end
        end
      end
      FLUSH: begin
        if (!valid_out || ready_out) begin
          ld      = 1'b1;
          ld_data = res_q;
          ld_keep = lead_ones(SW'(fl_q));
          ld_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      n_q          <= '0;
      fl_q         <= '0;
      res_q        <= '0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      keep_out     <= '0;
      last_out     <= 1'b0;
      header_out   <= '0;
      header_keep  <= '0;
      header_valid <= 1'b0;
    end else begin
      header_valid <= 1'b0;
      if (ld) begin
        valid_out <= 1'b1;
        data_out  <= ld_data;
        keep_out  <= ld_keep;
        last_out  <= ld_last;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (valid_remove) begin
            n_q   <= byte_remove_cnt;
            state <= FIRST;
          end
        end
        FIRST: begin
          if (accept) begin
            header_out   <= din & byte_mask(lead_ones(SW'(n_q)));
            header_keep  <= lead_ones(SW'(n_hdr));
            header_valid <= 1'b1;
            res_q        <= din_sh;
            state        <= last_in ? IDLE : BODY;
          end
        end
        BODY: begin
          if (accept) begin
            res_q <= din_sh;
            if (last_in) begin
              if (sum > SW'(W_CNT)) begin
                fl_q  <= fl_nxt;
                state <= FLUSH;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        FLUSH: begin
          if (!valid_out || ready_out)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// tb_axi_stream_remove_header: byte-stream reference model bench
// for axi_stream_remove_header with directed and random packets.

module tb_axi_stream_remove_header;

  localparam int BW = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
  logic        valid_remove = 1'b0;
  logic [2:0]  byte_remove_cnt = '0;
  logic        ready_remove;
  logic [31:0] header_out;
  logic [3:0]  header_keep;
  logic        header_valid;

  axi_stream_remove_header #(
    .DATA_WD(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .keep_in        (keep_in),
    .last_in        (last_in),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .keep_out       (keep_out),
    .last_out       (last_out),
    .ready_out      (ready_out),
    .valid_remove   (valid_remove),
    .byte_remove_cnt(byte_remove_cnt),
    .ready_remove   (ready_remove),
    .header_out     (header_out),
    .header_keep    (header_keep),
    .header_valid   (header_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [7:0]  pk_b[$];
  int          pk_len[$];
  beat_t       got_q[$];
  beat_t       exp_q[$];
  logic [35:0] hdr_q[$];
  logic [35:0] exp_hdr;

  int rmode = 0;
  int hold  = 0;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: ready_out = 1'b1;
      1: ready_out = ($urandom_range(0, 2) != 0);
      default: begin
        if (valid_out && hold < 3) begin
          ready_out = 1'b0;
          hold++;
        end else begin
          ready_out = 1'b1;
          hold = 0;
        end
      end
    endcase
  end

  logic  pv   = 1'b0;
  logic  pr   = 1'b0;
  logic  prst = 1'b1;
  beat_t pb;

  always @(negedge clk) begin
    if (pv && !pr && !prst)
      chk("hold", 64'({valid_out, data_out, keep_out, last_out}),
          64'({1'b1, pb}));
    if (valid_out && !ready_out)
      chk("rdy_in_full", 64'(ready_in), 64'(0));
    if (valid_out && ready_out && !rst)
      got_q.push_back({data_out, keep_out, last_out});
    if (header_valid && !rst)
      hdr_q.push_back({header_out, header_keep});
    pv   = valid_out;
    pr   = ready_out;
    prst = rst;
    pb   = {data_out, keep_out, last_out};
  end

  task automatic add_beat(input logic [31:0] d, input int len);
    for (int j = 0; j < len; j++)
      pk_b.push_back(d[31-8*j -: 8]);
    pk_len.push_back(len);
  endtask

  task automatic clr_pkt();
    pk_b.delete();
    pk_len.delete();
  endtask

  // Reference: header = first min(N,L0) bytes; payload = every byte
  // after the first N, packed W per word, last word flagged.
  task automatic model(input int n);
    int          h;
    int          sz;
    logic [31:0] hd;
    logic [3:0]  hk;
    beat_t       b;
    h  = (n < pk_len[0]) ? n : pk_len[0];
    hd = '0;
    hk = '0;
    for (int j = 0; j < h; j++) begin
      hd[31-8*j -: 8] = pk_b[j];
      hk[3-j] = 1'b1;
    end
    exp_hdr = {hd, hk};
    sz = pk_b.size();
    for (int s = n; s < sz; s += BW) begin
      b = '0;
      for (int j = 0; j < BW && s + j < sz; j++) begin
        b.d[31-8*j -: 8] = pk_b[s+j];
        b.k[3-j] = 1'b1;
      end
      b.l = (s + BW >= sz);
      exp_q.push_back(b);
    end
  endtask

  task automatic send(input int n, input int abort_at);
    int          off;
    int          w;
    logic [31:0] d;
    logic [3:0]  k;
    off = 0;
    @(posedge clk);
    #1;
    valid_remove    = 1'b1;
    byte_remove_cnt = 3'(n);
    w = 0;
    @(negedge clk);
    while (!ready_remove && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("desc_to", 64'(w < 50), 64'(1));
    @(posedge clk);
    #1;
    valid_remove = 1'b0;
    for (int i = 0; i < pk_len.size(); i++) begin
      d = $urandom;
      k = '0;
      for (int j = 0; j < pk_len[i]; j++) begin
        d[31-8*j -: 8] = pk_b[off+j];
        k[3-j] = 1'b1;
      end
      valid_in = 1'b1;
      data_in  = d;
      keep_in  = k;
      last_in  = (i == pk_len.size() - 1);
      w = 0;
      @(negedge clk);
      while (!ready_in && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk("in_to", 64'(w < 100), 64'(1));
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      last_in  = 1'b0;
      if (i + 1 == abort_at) return;
      off += pk_len[i];
      if (rmode == 1) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((got_q.size() < exp_q.size() || hdr_q.size() < 1)
           && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain_to", 64'(w < 300), 64'(1));
    repeat (6) @(negedge clk);
    chk("nbeat", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        chk("beat", 64'(got_q[i]), 64'(exp_q[i]));
    chk("nhdr", 64'(hdr_q.size()), 64'(1));
    if (hdr_q.size() > 0)
      chk("hdr", 64'(hdr_q[0]), 64'(exp_hdr));
    got_q.delete();
    exp_q.delete();
    hdr_q.delete();
  endtask

  task automatic run(input int n, input int rm);
    rmode = rm;
    model(n);
    send(n, 0);
    drain();
  endtask

  task automatic pkt_n2();
    clr_pkt();
    add_beat(32'hAABB0102, 4);
    add_beat(32'h03040506, 4);
    add_beat(32'h07080000, 2);
  endtask

  task automatic pkt_n1();
    clr_pkt();
    add_beat(32'hEE010203, 4);
    add_beat(32'h04050607, 4);
    add_beat(32'h08090A00, 3);
  endtask

  initial begin
    int n;
    int nb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({valid_out, last_out, header_valid,
                        ready_in, ready_remove, keep_out,
                        header_keep}), 64'(0));
    chk("rst_data", 64'({data_out, header_out}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rr", 64'(ready_remove), 64'(1));

    pkt_n2();
    run(2, 0);
    pkt_n1();
    run(1, 0);
    clr_pkt();
    add_beat(32'h11223344, 4);
    run(0, 0);
    clr_pkt();
    add_beat(32'hDEADBEEF, 4);
    run(4, 0);
    @(negedge clk);
    chk("n4_idle", 64'(ready_remove), 64'(1));

    pkt_n2();
    run(2, 2);

    rmode = 0;
    pkt_n1();
    send(1, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rr", 64'(ready_remove), 64'(0));
    @(posedge clk);
    #1;
    chk("mid_ctl", 64'({valid_out, last_out, header_valid,
                        ready_in, ready_remove, keep_out,
                        header_keep}), 64'(0));
    chk("mid_data", 64'({data_out, header_out}), 64'(0));
    rst = 1'b0;
    got_q.delete();
    hdr_q.delete();
    exp_q.delete();
    pkt_n2();
    run(2, 0);

    for (int t = 0; t < 40; t++) begin
      clr_pkt();
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++)
        add_beat($urandom,
                 (i == nb - 1) ? $urandom_range(1, 4) : 4);
      n = $urandom_range(0, 4);
      run(n, (t % 3 == 0) ? 2 : 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
